// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between a requester and the sequential divider.
// The requester owns start and the operands; the divider owns results and status.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes,
// with a final two's-complement sign fix. Truncating division, remainder follows the dividend.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] r, r_next;
    logic [WIDTH-1:0] q, q_next;
    logic [WIDTH-1:0] d, d_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             q_neg, q_neg_next;
    logic             r_neg, r_neg_next;

    logic [WIDTH-1:0] quotient_q, quotient_next;
    logic [WIDTH-1:0] remainder_q, remainder_next;
    logic             busy_q, busy_next;
    logic             done_q, done_next;
    logic             div_zero_q, div_zero_next;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // r < d <= 2^(WIDTH-1) always, so the shifted remainder fits and trial[WIDTH] is its sign.
    assign r_shift = {r, q[WIDTH-1]};
    assign trial   = r_shift - {1'b0, d};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        r_next         = r;
        q_next         = q;
        d_next         = d;
        cnt_next       = cnt;
        q_neg_next     = q_neg;
        r_neg_next     = r_neg;
        quotient_next  = quotient_q;
        remainder_next = remainder_q;
        busy_next      = busy_q;
        done_next      = 1'b0;
        div_zero_next  = div_zero_q;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    q_neg_next    = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    r_neg_next    = bus.dividend[WIDTH-1];
                    r_next        = '0;
                    q_next        = mag(bus.dividend);
                    d_next        = mag(bus.divisor);
                    cnt_next      = CNT_W'(WIDTH);
                    div_zero_next = 1'b0;
                    busy_next     = 1'b1;
                    state_next    = (bus.divisor == '0) ? DONE : BUSY;
                end
            end

            BUSY: begin
                if (!trial[WIDTH]) begin
                    r_next = trial[WIDTH-1:0];
                    q_next = {q[WIDTH-2:0], 1'b1};
                end else begin
                    r_next = r_shift[WIDTH-1:0];
                    q_next = {q[WIDTH-2:0], 1'b0};
                end
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                quotient_next  = apply_sign(q, q_neg);
                remainder_next = apply_sign(r, r_neg);
                done_next      = 1'b1;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end

            DONE: begin
                // q still holds |dividend|; re-applying its sign restores the captured dividend.
                quotient_next  = '1;
                remainder_next = apply_sign(q, r_neg);
                div_zero_next  = 1'b1;
                done_next      = 1'b1;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state       <= state_next;
            r           <= r_next;
            q           <= q_next;
            d           <= d_next;
            cnt         <= cnt_next;
            q_neg       <= q_neg_next;
            r_neg       <= r_neg_next;
            quotient_q  <= quotient_next;
            remainder_q <= remainder_next;
            busy_q      <= busy_next;
            done_q      <= done_next;
            div_zero_q  <= div_zero_next;
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;

endmodule
